// File: rtl/md_arbiter.sv
// Two-requester arbiter in front of a shared multi-cycle Mul/Div unit.
// It sequences the unit's en/busy protocol, returns results over valid/ready and aborts hung ops.
module md_arbiter #(
  parameter bit          RR_EN          = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk_n,
  input  logic        i_rst,
  input  logic [1:0]  i_req_valid,
  output logic [1:0]  o_req_ready,
  input  logic [63:0] i_req_a,
  input  logic [63:0] i_req_b,
  input  logic [5:0]  i_req_funct3,
  output logic [1:0]  o_rsp_valid,
  input  logic [1:0]  i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_unit_en,
  output logic [31:0] o_unit_a,
  output logic [31:0] o_unit_b,
  output logic [2:0]  o_unit_funct3,
  input  logic        i_unit_busy,
  input  logic [31:0] i_unit_result,
  output logic        o_owner,
  output logic        o_busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [7:0] WdogLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        grant;
  logic        accept;

  always_comb begin
    case (i_req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = RR_EN ? ~last_grant_q : 1'b0;
      default: grant = 1'b0;
    endcase
  end

  // Ready only advertised in idle, and never while reset is held.
  always_comb begin
    o_req_ready = 2'b00;
    if (state_q == StIdle && !i_rst && (|i_req_valid)) begin
      o_req_ready[grant] = 1'b1;
    end
  end

  assign accept = |(o_req_ready & i_req_valid);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    f3_d         = f3_q;
    data_d       = data_q;
    err_d        = err_q;
    wdog_d       = wdog_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          a_d          = grant ? i_req_a[63:32] : i_req_a[31:0];
          b_d          = grant ? i_req_b[63:32] : i_req_b[31:0];
          f3_d         = grant ? i_req_funct3[5:3] : i_req_funct3[2:0];
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        wdog_d  = 8'd1;
        state_d = StWait;
      end
      StWait: begin
        // Completion is checked first so a result on the timeout cycle is not lost.
        if (!i_unit_busy) begin
          data_d  = i_unit_result;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (wdog_q == WdogLast) begin
          data_d  = 32'd0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      StResp: begin
        if (i_rsp_ready[owner_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk_n) begin
    if (i_rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      f3_q         <= 3'd0;
      data_q       <= 32'd0;
      err_q        <= 1'b0;
      wdog_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      f3_q         <= f3_d;
      data_q       <= data_d;
      err_q        <= err_d;
      wdog_q       <= wdog_d;
    end
  end

  always_comb begin
    o_rsp_valid = 2'b00;
    if (state_q == StResp) begin
      o_rsp_valid[owner_q] = 1'b1;
    end
  end

  assign o_unit_en     = (state_q == StIssue) || (state_q == StWait);
  assign o_unit_a      = a_q;
  assign o_unit_b      = b_q;
  assign o_unit_funct3 = f3_q;
  assign o_rsp_data    = data_q;
  assign o_rsp_err     = err_q;
  assign o_owner       = owner_q;
  assign o_busy        = (state_q != StIdle);

endmodule

// File: tb/tb_md_arbiter.sv
// Directed bench for md_arbiter: scoreboard of expected responses, a behavioural Mul/Div unit,
// and a second fixed-priority instance for the arbitration-policy check.
module tb_md_arbiter;

  localparam int unsigned Timeout = 8;

  logic        clk_n = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_a, req_b;
  logic [5:0]  req_f3;
  logic [31:0] rsp_data, unit_a, unit_b, unit_result;
  logic [2:0]  unit_f3;
  logic        rsp_err, unit_en, unit_busy, owner, busy;

  logic [1:0]  fp_valid, fp_ready, fp_rsp_valid, fp_rsp_ready;
  logic [31:0] fp_rsp_data, fp_unit_a, fp_unit_b;
  logic [2:0]  fp_unit_f3;
  logic        fp_rsp_err, fp_unit_en, fp_owner, fp_busy;

  always #5 clk_n = ~clk_n;

  md_arbiter #(.RR_EN(1'b1), .TIMEOUT_CYCLES(Timeout)) dut (
    .i_clk_n(clk_n), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_funct3(req_f3), .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err), .o_unit_en(unit_en),
    .o_unit_a(unit_a), .o_unit_b(unit_b), .o_unit_funct3(unit_f3), .i_unit_busy(unit_busy),
    .i_unit_result(unit_result), .o_owner(owner), .o_busy(busy)
  );

  md_arbiter #(.RR_EN(1'b0), .TIMEOUT_CYCLES(Timeout)) dut_fp (
    .i_clk_n(clk_n), .i_rst(rst), .i_req_valid(fp_valid), .o_req_ready(fp_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_funct3(req_f3), .o_rsp_valid(fp_rsp_valid),
    .i_rsp_ready(fp_rsp_ready), .o_rsp_data(fp_rsp_data), .o_rsp_err(fp_rsp_err),
    .o_unit_en(fp_unit_en), .o_unit_a(fp_unit_a), .o_unit_b(fp_unit_b),
    .o_unit_funct3(fp_unit_f3), .i_unit_busy(1'b0), .i_unit_result(32'd0),
    .o_owner(fp_owner), .o_busy(fp_busy)
  );

  // Behavioural unit: busy for busy_len cycles after the issue cycle, or forever when stuck.
  int unsigned en_cnt = 0;
  int unsigned busy_len = 0;
  bit          stuck = 1'b0;
  always @(posedge clk_n) en_cnt <= unit_en ? en_cnt + 1 : 0;
  assign unit_busy   = unit_en && (stuck || en_cnt <= busy_len);
  assign unit_result = unit_a * unit_b;

  typedef struct {
    logic        owner;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic [31:0] data;
    logic        err;
    int          en_cycles;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic tb_last = 1'b1;

  task automatic tick();
    @(posedge clk_n);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f3);
    req_a[32*k +: 32] = a;
    req_b[32*k +: 32] = b;
    req_f3[3*k +: 3]  = f3;
    req_valid[k]      = 1'b1;
  endtask

  // Checks the grant, records the expected response, and takes the accepting edge.
  task automatic accept(input int k, input int unsigned blen, input bit stk);
    exp_t e;
    busy_len = blen;
    stuck    = stk;
    #1;
    check("req_ready_grant", req_ready, (k != 0) ? 2'b10 : 2'b01);
    e.owner     = (k != 0);
    e.a         = req_a[32*k +: 32];
    e.b         = req_b[32*k +: 32];
    e.f3        = req_f3[3*k +: 3];
    e.err       = stk || (blen >= Timeout - 1);
    e.data      = e.err ? 32'd0 : e.a * e.b;
    e.en_cycles = e.err ? int'(Timeout) : int'(blen) + 2;
    sb.push_back(e);
    tb_last = e.owner;
    tick();
    check("owner", owner, e.owner);
    check("busy_after_accept", busy, 1'b1);
  endtask

  task automatic complete(input int hold, input bit poke_other);
    exp_t e;
    int   en_cyc;
    e      = sb[0];
    en_cyc = 0;
    while (unit_en && en_cyc < 300) begin
      en_cyc++;
      check("unit_a_stable", unit_a, e.a);
      check("unit_b_stable", unit_b, e.b);
      check("unit_f3_stable", unit_f3, e.f3);
      check("req_ready_busy", req_ready, 2'b00);
      tick();
    end
    check("en_cycles", en_cyc, e.en_cycles);
    check("rsp_valid", rsp_valid, e.owner ? 2'b10 : 2'b01);
    for (int i = 0; i < hold; i++) begin
      if (poke_other) rsp_ready[~e.owner] = 1'b1;
      tick();
      check("hold_rsp_valid", rsp_valid, e.owner ? 2'b10 : 2'b01);
      check("hold_rsp_data", rsp_data, e.data);
      check("hold_unit_en", unit_en, 1'b0);
      check("hold_req_ready", req_ready, 2'b00);
    end
    rsp_ready = 2'b00;
    check("rsp_data", rsp_data, e.data);
    check("rsp_err", rsp_err, e.err);
    rsp_ready[e.owner] = 1'b1;
    tick();
    rsp_ready = 2'b00;
    void'(sb.pop_front());
    check("rsp_valid_drop", rsp_valid, 2'b00);
    check("idle_after_rsp", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int grants;
    rst = 1'b1;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_a = '0; req_b = '0; req_f3 = '0;
    fp_valid = 2'b00; fp_rsp_ready = 2'b00;
    tick(); tick();
    // Reset state, with a request pending that must not be readied.
    req_valid = 2'b01;
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_unit_en", unit_en, 1'b0);
    check("rst_unit_a", unit_a, 32'd0);
    check("rst_unit_b", unit_b, 32'd0);
    check("rst_unit_f3", unit_f3, 3'd0);
    check("rst_owner", owner, 1'b0);
    check("rst_busy", busy, 1'b0);
    req_valid = 2'b00;
    rst = 1'b0;
    tick();

    // Basic multiply: 3*5, busy four cycles.
    drive(0, 32'd3, 32'd5, 3'b000);
    accept(0, 4, 1'b0);
    req_valid = 2'b00;
    complete(0, 1'b0);

    // Response back-pressure with the non-owner's ready wiggled.
    drive(1, 32'h1234, 32'h10, 3'b101);
    accept(1, 2, 1'b0);
    req_valid = 2'b00;
    complete(5, 1'b1);

    // Stuck unit hits the watchdog.
    drive(0, 32'd11, 32'd13, 3'b001);
    accept(0, 0, 1'b1);
    req_valid = 2'b00;
    complete(0, 1'b0);
    stuck = 1'b0;

    // Busy drops exactly on the timeout cycle: completion wins.
    drive(1, 32'hffff, 32'd3, 3'b011);
    accept(1, Timeout - 2, 1'b0);
    req_valid = 2'b00;
    complete(0, 1'b0);

    // Busy still high on the timeout cycle: abort.
    drive(0, 32'd21, 32'd2, 3'b010);
    accept(0, Timeout - 1, 1'b0);
    req_valid = 2'b00;
    complete(0, 1'b0);

    // Round-robin with both requesters held valid.
    drive(0, 32'd7, 32'd6, 3'b000);
    drive(1, 32'd9, 32'd4, 3'b000);
    for (int i = 0; i < 4; i++) begin
      accept(tb_last ? 0 : 1, 1, 1'b0);
      complete(0, 1'b0);
    end
    req_valid = 2'b00;

    // Reset in WAIT: silent abort, pending request taken after release.
    drive(0, 32'd8, 32'd9, 3'b000);
    accept(0, 5, 1'b0);
    tick();
    check("pre_rst_unit_en", unit_en, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_pulse_req_ready", req_ready, 2'b00);
    tick();
    check("rst_pulse_unit_en", unit_en, 1'b0);
    check("rst_pulse_rsp_valid", rsp_valid, 2'b00);
    check("rst_pulse_busy", busy, 1'b0);
    void'(sb.pop_back());
    tb_last = 1'b1;
    rst = 1'b0;
    accept(0, 0, 1'b0);
    req_valid = 2'b00;
    complete(0, 1'b0);

    // Fixed priority: requester 0 wins every time while held valid.
    fp_valid = 2'b11;
    fp_rsp_ready = 2'b11;
    grants = 0;
    for (int i = 0; i < 16; i++) begin
      if (|fp_ready) begin
        check("fp_grant", fp_ready, 2'b01);
        grants++;
      end
      if (|fp_rsp_valid) check("fp_rsp_owner", fp_rsp_valid, 2'b01);
      tick();
    end
    check("fp_grant_count", (grants >= 3), 1'b1);
    fp_valid = 2'b00;
    fp_rsp_ready = 2'b00;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
